// File: rtl/uart_rx_byte_fifo.sv
// Byte FIFO behind the UART RX sampler: rising-edge capture of data_valid and frame_err,
// a show-ahead read port, a sticky overflow flag and a saturating frame-error counter.
module uart_rx_byte_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CNT_W        = 8,
  parameter bit          AUTO_ERR_CLR = 1'b1
) (
  input  logic                     clk_sample,
  input  logic                     RST_N,
  input  logic [7:0]               data_rx,
  input  logic                     data_valid,
  input  logic                     frame_err,
  output logic                     Err_clr,
  input  logic                     err_clr_req,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_d;
  logic             rd_valid_d;
  logic             ovf_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic             err_clr_d;
  logic             dv_q, fe_q;

  logic             dv_rise, fe_rise;
  logic             push_req, push_ok, pop, full, ovf_set;

  // Next-state computation for pointers, occupancy, flags and error counter
  always_comb begin
    dv_rise    = data_valid & ~dv_q;
    fe_rise    = frame_err & ~fe_q;
    full       = (count == OCC_W'(DEPTH));
    pop        = rd_valid & rd_ready;
    push_req   = dv_rise & ~fe_rise;
    // A push into a full FIFO only fits if the head leaves on the same edge
    push_ok    = push_req & (~full | pop);
    ovf_set    = push_req & full & ~pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count;
    ovf_d      = ovf;
    err_cnt_d  = err_cnt;
    err_clr_d  = 1'b0;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push_ok, pop})
      2'b10:   count_d = count + OCC_W'(1);
      2'b01:   count_d = count - OCC_W'(1);
      default: count_d = count;
    endcase
    rd_valid_d = (count_d != '0);

    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

    if (err_clr_req)                      err_cnt_d = fe_rise ? CNT_W'(1) : '0;
    else if (fe_rise && err_cnt != ERR_MAX) err_cnt_d = err_cnt + CNT_W'(1);

    err_clr_d = (AUTO_ERR_CLR & fe_rise) | err_clr_req;
  end

  always_ff @(posedge clk_sample or negedge RST_N) begin
    if (!RST_N) begin
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      err_cnt  <= '0;
      Err_clr  <= 1'b0;
    end else begin
      dv_q     <= data_valid;
      fe_q     <= frame_err;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count    <= count_d;
      rd_valid <= rd_valid_d;
      ovf      <= ovf_d;
      err_cnt  <= err_cnt_d;
      Err_clr  <= err_clr_d;
    end
  end

  // Storage is not reset; pointers alone define validity
  always_ff @(posedge clk_sample) begin
    if (push_ok) mem[wr_ptr_q] <= data_rx;
  end

  assign rd_data = mem[rd_ptr_q];

endmodule

// File: doc/uart_rx_byte_fifo.md
Name: uart_rx_byte_fifo

Overview:
Downstream consumer of the UART RX sampler. It captures each received byte on the rising edge of the sampler's data_valid and buffers it in a show-ahead FIFO. Consumers drain the FIFO through a valid/ready read port. The block drops frames flagged with frame_err, counts them, and drives the sampler's Err_clr line to re-arm it.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
CNT_W, 8, width of the frame-error counter.
AUTO_ERR_CLR, 1, 1 = pulse Err_clr automatically after each frame error; 0 = only on err_clr_req.

Ports:
clk_sample  in  1  16x oversample clock; same domain as the sampler outputs, so no CDC.
RST_N  in  1  global reset, asynchronous, active-low.
data_rx  in  8  byte from the sampler.
data_valid  in  1  sampler byte-valid; level or pulse, and only the rising edge is used.
frame_err  in  1  sampler stop-bit error; only the rising edge is used.
Err_clr  out  1  one-cycle clear pulse to the sampler.
err_clr_req  in  1  software request for Err_clr; also clears err_cnt.
rd_data  out  8  head-of-FIFO byte (show-ahead).
rd_valid  out  1  FIFO non-empty.
rd_ready  in  1  consumer accepts rd_data when rd_valid & rd_ready.
count  out  $clog2(DEPTH)+1  current occupancy.
ovf  out  1  sticky overflow flag.
ovf_clr  in  1  clears ovf.
err_cnt  out  CNT_W  saturating frame-error count.

Behaviour:
- Reset (RST_N low, asynchronous):
  - rd_valid=0, count=0, ovf=0, err_cnt=0, Err_clr=0.
  - Pointers are zeroed and the edge-detect registers are set to 0.
  - Memory contents are don't-care; rd_data is don't-care while rd_valid=0.
- Edge detect:
  - dv_q and fe_q register data_valid and frame_err every cycle.
  - dv_rise = data_valid & ~dv_q; fe_rise = frame_err & ~fe_q.
  - A level held high for many cycles produces exactly one event.
- Push:
  - On a clock edge where dv_rise=1 and fe_rise=0, data_rx is written at wr_ptr.
  - Latency: data_valid rises before clock edge N; the byte is written at N; rd_valid=1 after N when the FIFO was empty.
  - There is no empty-bypass.
- Frame error:
  - fe_rise drops any simultaneous dv_rise; nothing is pushed.
  - err_cnt increments and saturates at 2^CNT_W-1.
- Err_clr:
  - Registered output.
  - High for exactly one cycle, the cycle after any edge where (AUTO_ERR_CLR & fe_rise) | err_clr_req.
  - err_clr_req resets err_cnt to 0 on that edge; if fe_rise occurs on the same edge, err_cnt becomes 1.
- Pop:
  - rd_valid & rd_ready advances rd_ptr.
  - rd_data = mem[rd_ptr] combinationally.
  - rd_ready while empty is ignored.
- Occupancy:
  - count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Full = (count==DEPTH).
- Full boundary:
  - Push while full with no pop: byte dropped, ovf set, count stays DEPTH.
  - Push and pop together while full: both accepted, count stays DEPTH, no ovf.
- Empty boundary: push and pop together while empty performs the push only and no pop (count becomes 1).
- ovf:
  - Sticky until ovf_clr.
  - If ovf_clr and a new overflow occur on the same edge, ovf stays 1 (set wins).
- Reset mid-operation flushes the FIFO immediately and drops any in-flight edge.
- No FSM beyond the edge detectors; the design is pointer/counter based, targeting about 150–250 lines.

Test Plan:
- Reset, then pulse data_valid with data_rx=8'hFF (all-ones payload) -> rd_valid=1 one edge later, rd_data=8'hFF, count=1; rd_ready for 1 cycle -> count=0, rd_valid=0.
- Hold data_valid high for 20 cycles with data_rx=8'hA5 -> exactly one entry, count=1.
- frame_err and data_valid rise together with data_rx=8'h3C (AUTO_ERR_CLR=1) -> no push, count=0, err_cnt=1, Err_clr high for exactly 1 cycle on the following cycle.
- Push 17 bytes 8'h00..8'h10 with DEPTH=16 and rd_ready=0 -> count=16, ovf=1; drain returns 8'h00..8'h0F in order; ovf_clr -> ovf=0.
- Wrap test: fill 16, pop 1, push 8'h55 on the same edge as a pop while full -> count stays 16, no ovf; the last entry read out is 8'h55.
- 300 frame errors with CNT_W=8 -> err_cnt=255 saturated; err_clr_req -> err_cnt=0, Err_clr pulses once; assert RST_N low with 5 entries queued -> count=0, rd_valid=0 asynchronously.
